perf_display_scan: RTL

Display back-end for the single-cycle MIPS core. It consumes the core's `Leddata`, `Count_all`, `Count_branch` and `Count_jmp` outputs and time-multiplexes one selected 32-bit value as eight hex digits onto a common-anode 7-segment bank. Values are snapshotted only at frame boundaries, so a digit never changes mid-scan.

---
 rtl/perf_display_scan.sv | 112 +++++++++++
 1 files changed

// File: rtl/perf_display_scan.sv
// Purpose: scans one sel-chosen 32-bit core value as 8 hex digits on a common-anode 7-segment bank;
//          snapshot taken only at frame boundaries. Optional PERF_DISP_LZ_BLANK_EN blanks leading zeros.
// Latency: an/seg registered, one cycle behind dig/shadow; no backpressure (free-running display output).
module perf_display_scan #(
  parameter int SCAN_DIV = 100000
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [1:0]  sel,
  input  logic        freeze,
  input  logic [31:0] Leddata,
  input  logic [31:0] Count_all,
  input  logic [31:0] Count_branch,
  input  logic [31:0] Count_jmp,
  output logic [7:0]  an,
  output logic [7:0]  seg
);

  localparam int              DW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DW-1:0]   DIV_LAST = DW'(SCAN_DIV - 1);

  logic [DW-1:0] div_cnt;
  logic [2:0]    dig;
  logic [31:0]   shadow;
  logic          tick;
  logic          boundary;
  logic [31:0]   src_dat;
  logic [3:0]    nib;
  logic [6:0]    hex_seg;
  logic          blank;

  assign tick     = (div_cnt == DIV_LAST);
  assign boundary = tick && (dig == 3'd7);

  // Source mux; only sampled into shadow at the frame boundary.
  always_comb begin
    src_dat = Leddata;
    case (sel)
      2'd0: src_dat = Leddata;
      2'd1: src_dat = Count_all;
      2'd2: src_dat = Count_branch;
      2'd3: src_dat = Count_jmp;
      default: src_dat = Leddata;
    endcase
  end

  // Prescaler: one digit slot every SCAN_DIV cycles.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr)      div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + 1'b1;
  end

  // Digit index advances once per slot and wraps 7->0 naturally.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr)      dig <= 3'd0;
    else if (tick) dig <= dig + 3'd1;
  end

  // Snapshot at the 7->0 transition so a digit never changes mid-frame.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr)                      shadow <= 32'd0;
    else if (boundary && !freeze)  shadow <= src_dat;
  end

  assign nib = shadow[{dig, 2'b00} +: 4];

  // Active-low hex decode, segments g..a.
  always_comb begin
    hex_seg = 7'h7F;
    case (nib)
      4'h0: hex_seg = 7'h40;
      4'h1: hex_seg = 7'h79;
      4'h2: hex_seg = 7'h24;
      4'h3: hex_seg = 7'h30;
      4'h4: hex_seg = 7'h19;
      4'h5: hex_seg = 7'h12;
      4'h6: hex_seg = 7'h02;
      4'h7: hex_seg = 7'h78;
      4'h8: hex_seg = 7'h00;
      4'h9: hex_seg = 7'h10;
      4'hA: hex_seg = 7'h08;
      4'hB: hex_seg = 7'h03;
      4'hC: hex_seg = 7'h46;
      4'hD: hex_seg = 7'h21;
      4'hE: hex_seg = 7'h06;
      4'hF: hex_seg = 7'h0E;
      default: hex_seg = 7'h7F;
    endcase
  end

`ifdef PERF_DISP_LZ_BLANK_EN
  // A digit is a leading zero when it and every more significant nibble are zero; digit 0 always shows.
  logic [31:0] upper;
  assign upper = shadow >> {dig, 2'b00};
  assign blank = (dig != 3'd0) && (upper == 32'd0);
`else
  assign blank = 1'b0;
`endif

  // Output register: anode one-hot-low and segments, dp always off.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      an  <= 8'hFF;
      seg <= 8'hFF;
    end else begin
      an  <= ~(8'b1 << dig);
      seg <= blank ? 8'hFF : {1'b1, hex_seg};
    end
  end

endmodule
